// File: rtl/cr_cceip_ib_arb.sv
// cr_cceip_ib_arb: frame-level round-robin arbiter that multiplexes N_REQ
// AXI-Stream job sources onto the single CCE engine inbound port. A granted
// source owns the port until its tlast beat is accepted. The output is driven
// from a 2-entry skid buffer, so backpressure costs no throughput.
module cr_cceip_ib_arb #(
  parameter int N_REQ = 4,
  parameter int DW    = 64,
  parameter int SW    = 8,
  parameter int UW    = 8,
  parameter int TIDW  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    src_tvalid,
  output logic [N_REQ-1:0]    src_tready,
  input  logic [N_REQ*DW-1:0] src_tdata,
  input  logic [N_REQ*SW-1:0] src_tstrb,
  input  logic [N_REQ*UW-1:0] src_tuser,
  input  logic [N_REQ-1:0]    src_tlast,
  output logic                ib_tvalid,
  input  logic                ib_tready,
  output logic [DW-1:0]       ib_tdata,
  output logic [SW-1:0]       ib_tstrb,
  output logic [UW-1:0]       ib_tuser,
  output logic                ib_tlast,
  output logic [TIDW-1:0]     ib_tid,
  output logic                arb_idle,
  output logic [31:0]         frame_cnt
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int EW = DW + SW + UW + 1 + TIDW;

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr, rr_nxt;
  logic [IW-1:0]   grant, grant_nxt;
  logic [IW-1:0]   sel;
  logic            sel_vld;

  logic [DW-1:0]   beat_d;
  logic [SW-1:0]   beat_s;
  logic [UW-1:0]   beat_u;
  logic            beat_l;
  logic [EW-1:0]   beat_in;

  // skid_p0 is the head entry feeding ib_*, skid_p1 the entry behind it
  logic [EW-1:0]   skid_p0, skid_p1;
  logic [1:0]      cnt;
  logic            push, pop;

  // Round-robin search: first valid source starting at rr_ptr, wrapping mod N_REQ
  always_comb begin
    logic [IW:0] idx;
    sel     = '0;
    sel_vld = 1'b0;
    idx     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (IW+1)'(k);
      if (idx >= (IW+1)'(N_REQ)) idx = idx - (IW+1)'(N_REQ);
      if (src_tvalid[idx[IW-1:0]]) begin
        sel     = idx[IW-1:0];
        sel_vld = 1'b1;
      end
    end
  end

  // Select the granted source's beat fields
  always_comb begin
    beat_d = '0;
    beat_s = '0;
    beat_u = '0;
    beat_l = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant == IW'(i)) begin
        beat_d = src_tdata[i*DW +: DW];
        beat_s = src_tstrb[i*SW +: SW];
        beat_u = src_tuser[i*UW +: UW];
        beat_l = src_tlast[i];
      end
    end
  end

  assign beat_in    = {beat_d, beat_s, beat_u, beat_l, TIDW'(grant)};
  assign src_tready = (state == XFER && cnt != 2'd2) ? (N_REQ'(1) << grant) : '0;
  assign push       = (state == XFER) && src_tvalid[grant] && (cnt != 2'd2);
  assign pop        = (cnt != 2'd0) && ib_tready;

  // Next-state logic: one grant cycle in IDLE, release the port on the tlast beat
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    rr_nxt    = rr_ptr;
    case (state)
      IDLE: begin
        if (sel_vld) begin
          grant_nxt = sel;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (push && beat_l) begin
          state_nxt = IDLE;
          rr_nxt    = (grant == IW'(N_REQ - 1)) ? '0 : grant + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Arbiter state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  // Skid buffer: in-order 2-entry FIFO; entries are cleared on reset so ib_* reads zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 2'd0;
      skid_p0 <= '0;
      skid_p1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) skid_p0 <= beat_in;
          else             skid_p1 <= beat_in;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          skid_p0 <= skid_p1;
          cnt     <= cnt - 2'd1;
        end
        2'b11: begin
          // push needs cnt<2 and pop needs cnt>0, so exactly one entry is held here
          skid_p0 <= beat_in;
        end
        default: ;
      endcase
    end
  end

  // Completed-frame counter, stepped when the tlast beat leaves the buffer
  always_ff @(posedge clk) begin
    if (rst) frame_cnt <= '0;
    else if (pop && ib_tlast) frame_cnt <= frame_cnt + 32'd1;
  end

  assign {ib_tdata, ib_tstrb, ib_tuser, ib_tlast, ib_tid} = skid_p0;
  assign ib_tvalid = (cnt != 2'd0);
  assign arb_idle  = (state == IDLE) && (cnt == 2'd0);

endmodule

// File: tb/tb_cr_cceip_ib_arb.sv
// Testbench for cr_cceip_ib_arb: per-source beat queues drive the inputs and a
// queue-based reference model predicts every output cycle by cycle.
module tb_cr_cceip_ib_arb;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    src_tvalid;
  logic [N-1:0]    src_tready;
  logic [N*64-1:0] src_tdata;
  logic [N*8-1:0]  src_tstrb;
  logic [N*8-1:0]  src_tuser;
  logic [N-1:0]    src_tlast;
  logic            ib_tvalid;
  logic            ib_tready;
  logic [63:0]     ib_tdata;
  logic [7:0]      ib_tstrb;
  logic [7:0]      ib_tuser;
  logic            ib_tlast;
  logic [2:0]      ib_tid;
  logic            arb_idle;
  logic [31:0]     frame_cnt;

  always #5 clk = ~clk;

  cr_cceip_ib_arb #(.N_REQ(N), .DW(64), .SW(8), .UW(8), .TIDW(3)) dut (
    .clk(clk), .rst(rst),
    .src_tvalid(src_tvalid), .src_tready(src_tready), .src_tdata(src_tdata),
    .src_tstrb(src_tstrb), .src_tuser(src_tuser), .src_tlast(src_tlast),
    .ib_tvalid(ib_tvalid), .ib_tready(ib_tready), .ib_tdata(ib_tdata),
    .ib_tstrb(ib_tstrb), .ib_tuser(ib_tuser), .ib_tlast(ib_tlast),
    .ib_tid(ib_tid), .arb_idle(arb_idle), .frame_cnt(frame_cnt)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  s;
    logic [7:0]  u;
    logic        l;
  } beat_t;

  typedef struct packed {
    beat_t      b;
    logic [2:0] tid;
  } obeat_t;

  beat_t      srcq [N][$];
  obeat_t     mq[$];
  int         m_owner;
  int         m_rr;
  logic [31:0] m_fcnt;

  logic [N-1:0] acc;
  int          n_checks = 0;
  int          n_errors = 0;
  int          pv [N];
  int          trdy_mode;
  int          cyc = 0;
  logic [2:0]  tid_log[$];
  logic        sof;
  logic        stall_prev;
  logic [63:0] data_prev;
  logic [7:0]  user_prev;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic add_beat(input int src, input logic [63:0] d, input logic [7:0] s,
                          input logic [7:0] u, input logic l);
    beat_t bt;
    bt.d = d; bt.s = s; bt.u = u; bt.l = l;
    srcq[src].push_back(bt);
  endtask

  task automatic add_frame(input int src, input int len);
    for (int b = 0; b < len; b++)
      add_beat(src, {$urandom, $urandom}, 8'($urandom), 8'($urandom), b == len - 1);
  endtask

  function automatic bit pending();
    bit p;
    p = (m_owner >= 0) || (mq.size() != 0);
    for (int i = 0; i < N; i++) if (srcq[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  // Compare DUT outputs with the model's view after the latest clock edge
  task automatic compare();
    logic [N-1:0] er;
    er = '0;
    if (m_owner >= 0 && mq.size() < 2) er = N'(1) << m_owner;
    chk("ib_tvalid", 64'(ib_tvalid), 64'(mq.size() != 0));
    chk("src_tready", 64'(src_tready), 64'(er));
    chk("frame_cnt", 64'(frame_cnt), 64'(m_fcnt));
    chk("arb_idle", 64'(arb_idle), 64'(m_owner < 0 && mq.size() == 0));
    if (mq.size() != 0) begin
      chk("ib_tdata", ib_tdata, mq[0].b.d);
      chk("ib_tstrb", 64'(ib_tstrb), 64'(mq[0].b.s));
      chk("ib_tuser", 64'(ib_tuser), 64'(mq[0].b.u));
      chk("ib_tlast", 64'(ib_tlast), 64'(mq[0].b.l));
      chk("ib_tid", 64'(ib_tid), 64'(mq[0].tid));
    end
    if (stall_prev) begin
      chk("hold_tdata", ib_tdata, data_prev);
      chk("hold_tuser", 64'(ib_tuser), 64'(user_prev));
    end
  endtask

  // Drive sources (AXI hold rule) and ib_tready for the coming edge
  task automatic drive();
    beat_t tmp;
    logic  hold;
    for (int i = 0; i < N; i++) begin
      if (acc[i] && srcq[i].size() != 0) tmp = srcq[i].pop_front();
      hold = src_tvalid[i] && !acc[i] && (srcq[i].size() != 0);
      if (hold) src_tvalid[i] = 1'b1;
      else src_tvalid[i] = (srcq[i].size() != 0) && (int'($urandom_range(99)) < pv[i]);
      if (srcq[i].size() != 0) begin
        src_tdata[i*64 +: 64] = srcq[i][0].d;
        src_tstrb[i*8 +: 8]   = srcq[i][0].s;
        src_tuser[i*8 +: 8]   = srcq[i][0].u;
        src_tlast[i]          = srcq[i][0].l;
      end else begin
        src_tdata[i*64 +: 64] = {$urandom, $urandom};
        src_tstrb[i*8 +: 8]   = 8'($urandom);
        src_tuser[i*8 +: 8]   = 8'($urandom);
        src_tlast[i]          = 1'($urandom);
      end
    end
    case (trdy_mode)
      0:       ib_tready = 1'b1;
      1:       ib_tready = 1'($urandom_range(1));
      default: ib_tready = (cyc % 3 == 0);
    endcase
    acc = src_tvalid & src_tready & {N{~rst}};
    if (rst) sof = 1'b1;
    else if (ib_tvalid && ib_tready) begin
      if (sof) tid_log.push_back(ib_tid);
      sof = ib_tlast;
    end
    stall_prev = ib_tvalid && !ib_tready && !rst;
    data_prev  = ib_tdata;
    user_prev  = ib_tuser;
  endtask

  // Reference model: frame-owner + beat queue, advanced once per clock edge
  task automatic model_step();
    bit     was_idle;
    bit     do_pop;
    bit     do_push;
    int     sz;
    obeat_t nb;
    obeat_t tmp;
    if (rst) begin
      m_owner = -1;
      m_rr    = 0;
      mq.delete();
      m_fcnt  = '0;
      return;
    end
    was_idle = (m_owner < 0);
    sz       = mq.size();
    do_pop   = (sz != 0) && ib_tready;
    do_push  = !was_idle && src_tvalid[m_owner] && (sz < 2);
    nb       = '0;
    if (do_push) begin
      nb.b.d = src_tdata[m_owner*64 +: 64];
      nb.b.s = src_tstrb[m_owner*8 +: 8];
      nb.b.u = src_tuser[m_owner*8 +: 8];
      nb.b.l = src_tlast[m_owner];
      nb.tid = 3'(m_owner);
    end
    if (do_pop) begin
      if (mq[0].b.l) m_fcnt = m_fcnt + 32'd1;
      tmp = mq.pop_front();
    end
    if (do_push) begin
      mq.push_back(nb);
      if (nb.b.l) begin
        m_rr    = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
    if (was_idle) begin
      for (int k = 0; k < N; k++) begin
        if (src_tvalid[(m_rr + k) % N]) begin
          m_owner = (m_rr + k) % N;
          break;
        end
      end
    end
  endtask

  task automatic cycle();
    compare();
    drive();
    model_step();
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < N; i++) srcq[i].delete();
    src_tvalid = '0;
    acc = '0;
    run(n);
    rst = 1'b0;
    chk("rst_ib_tvalid", 64'(ib_tvalid), 64'd0);
    chk("rst_ib_tdata", ib_tdata, 64'd0);
    chk("rst_ib_tuser", 64'(ib_tuser), 64'd0);
    chk("rst_ib_tid", 64'(ib_tid), 64'd0);
    chk("rst_ib_tlast", 64'(ib_tlast), 64'd0);
    chk("rst_src_tready", 64'(src_tready), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_arb_idle", 64'(arb_idle), 64'd1);
  endtask

  task automatic chk_order(input string tag, input int exp_ord[$]);
    if (tid_log.size() < exp_ord.size())
      chk({tag, "_frames"}, 64'(tid_log.size()), 64'(exp_ord.size()));
    else
      for (int k = 0; k < exp_ord.size(); k++)
        chk(tag, 64'(tid_log[k]), 64'(exp_ord[k]));
  endtask

  initial begin
    int          guard;
    logic [31:0] fc0;
    rst = 1'b1;
    src_tvalid = '0; src_tdata = '0; src_tstrb = '0; src_tuser = '0; src_tlast = '0;
    ib_tready = 1'b0;
    acc = '0; sof = 1'b1; stall_prev = 1'b0; data_prev = '0; user_prev = '0;
    trdy_mode = 0;
    for (int i = 0; i < N; i++) pv[i] = 100;
    model_step();
    @(negedge clk);
    do_reset(2);

    // Single 3-beat frame from source 0
    add_beat(0, 64'h11, 8'hff, 8'h01, 1'b0);
    add_beat(0, 64'h22, 8'hff, 8'h00, 1'b0);
    add_beat(0, 64'h33, 8'h0f, 8'h02, 1'b1);
    tid_log.delete();
    run(8);
    chk("t1_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("t1_arb_idle", 64'(arb_idle), 64'd1);
    chk_order("t1_tid", '{0});

    // All sources continuously valid with 2-beat frames
    do_reset(1);
    tid_log.delete();
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) add_frame(i, 2);
    run(40);
    chk_order("t2_order", '{0, 1, 2, 3, 0, 1, 2, 3});
    chk("t2_frame_cnt", 64'(frame_cnt), 64'd8);

    // Source 1 streams 8 beats under a 1,0,0 ready pattern
    trdy_mode = 2;
    fc0 = frame_cnt;
    add_frame(1, 8);
    run(40);
    chk("t3_frame_cnt", 64'(frame_cnt), 64'(fc0 + 32'd1));

    // Source 2 back-to-back single-beat frames with tuser 8'h03
    trdy_mode = 0;
    fc0 = frame_cnt;
    tid_log.delete();
    for (int k = 0; k < 4; k++) add_beat(2, {$urandom, $urandom}, 8'hff, 8'h03, 1'b1);
    run(16);
    chk("t4_frame_cnt", 64'(frame_cnt), 64'(fc0 + 32'd4));
    chk_order("t4_tid", '{2, 2, 2, 2});

    // Reset in the middle of a 4-beat frame from source 3
    add_frame(3, 4);
    run(3);
    do_reset(1);
    tid_log.delete();
    add_frame(1, 1);
    add_frame(3, 1);
    run(10);
    chk_order("t5_order", '{1, 3});

    // rr_ptr at 3 with sources 0 and 3 both valid
    tid_log.delete();
    add_frame(2, 1);
    run(6);
    add_frame(0, 1);
    add_frame(3, 1);
    run(10);
    chk_order("t6_order", '{2, 3, 0});

    // Randomized traffic with random backpressure
    trdy_mode = 1;
    do_reset(1);
    for (int i = 0; i < N; i++) begin
      pv[i] = int'($urandom_range(100, 20));
      repeat (20) add_frame(i, int'($urandom_range(4, 1)));
    end
    guard = 0;
    while (pending() && guard < 8000) begin
      cycle();
      guard++;
    end
    chk("rand_drain_timeout", 64'(guard < 8000), 64'd1);
    run(2);
    chk("rand_frame_cnt", 64'(frame_cnt), 64'd80);

    // Randomized traffic interrupted by a reset
    for (int i = 0; i < N; i++) repeat (10) add_frame(i, int'($urandom_range(4, 1)));
    run(100);
    do_reset(2);
    for (int i = 0; i < N; i++) repeat (5) add_frame(i, int'($urandom_range(4, 1)));
    guard = 0;
    while (pending() && guard < 8000) begin
      cycle();
      guard++;
    end
    chk("rand2_drain_timeout", 64'(guard < 8000), 64'd1);
    run(2);
    chk("rand2_frame_cnt", 64'(frame_cnt), 64'd20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cr_cceip_ib_arb.md
Name: cr_cceip_ib_arb

Overview:
- N-way frame-level round-robin arbiter that shares the single 64-bit AXI-Stream inbound port of the CCE engine (ib_*) between multiple job sources.
- A frame is every beat from grant up to and including the beat with tlast=1. Once a source is granted, it owns the port until its frame completes; frames are never interleaved.
- Output is registered through a 2-entry skid buffer, giving full throughput under backpressure. ib_tid carries the index of the granted source.
- Sits between the host-side DMA/job queues and the engine ib_* port.

Parameters:
- N_REQ, 4, number of requesting sources (2..8).
- DW, 64, tdata width.
- SW, 8, tstrb width (DW/8).
- UW, 8, tuser width.
- TIDW, 3, ib_tid width; must satisfy TIDW >= clog2(N_REQ).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- src_tvalid  in  N_REQ  per-source valid.
- src_tready  out  N_REQ  per-source ready.
- src_tdata  in  N_REQ*DW  packed data; source i occupies [i*DW +: DW].
- src_tstrb  in  N_REQ*SW  packed byte strobes.
- src_tuser  in  N_REQ*UW  packed tuser (SoT=8'h01, EoT=8'h02).
- src_tlast  in  N_REQ  per-source end-of-frame.
- ib_tvalid  out  1  to engine.
- ib_tready  in  1  from engine.
- ib_tdata  out  DW  data.
- ib_tstrb  out  SW  strobes.
- ib_tuser  out  UW  tuser, passed unmodified.
- ib_tlast  out  1  end of frame.
- ib_tid  out  TIDW  granted source index, zero-extended.
- arb_idle  out  1  1 when no frame is in flight and the skid buffer is empty.
- frame_cnt  out  32  count of completed frames delivered to ib (beat with ib_tlast accepted); wraps at 2^32.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, rr_ptr=0, skid count=0.
  - ib_tvalid=0; ib_tdata, ib_tstrb, ib_tuser, ib_tlast, ib_tid all 0.
  - src_tready=0, frame_cnt=0, arb_idle=1.
  - Reset mid-frame discards the buffered beats and the grant; there is no recovery of the partial frame.
- State IDLE:
  - src_tready = 0 for all sources.
  - If any src_tvalid is high, grant g = first index i with src_tvalid[i]=1, searching i = rr_ptr, rr_ptr+1, ... modulo N_REQ. Register g and go to XFER.
  - The grant decision takes exactly one cycle; no beat is accepted in that cycle.
- State XFER:
  - src_tready[g] = (skid count < 2). All other src_tready = 0.
  - A beat is accepted when src_tvalid[g] && src_tready[g]. It is pushed into the skid buffer together with tid = g.
  - When the accepted beat has tlast=1: rr_ptr <= (g+1) mod N_REQ, next state IDLE. This costs one bubble cycle between frames.
  - Ungranted sources may raise or drop tvalid freely; this has no effect on the grant.
- Skid buffer (2-entry FIFO):
  - ib_tvalid = (count != 0). ib_* outputs come from the head entry and are driven directly from registers.
  - Pop when ib_tvalid && ib_tready.
  - A push and a pop in the same cycle leave count unchanged and keep data in order.
  - A push at count=2 is impossible by construction, because ready is deasserted at count=2.
  - Latency from source acceptance to ib_tvalid is 1 cycle when the buffer is empty.
  - ib_* outputs hold stable while ib_tvalid=1 and ib_tready=0.
- frame_cnt increments by 1 on each pop with ib_tlast=1.
- arb_idle = (state==IDLE) && (count==0), driven from registers.
- Fairness: after source g completes a frame, g has the lowest priority at the next arbitration. No source waits longer than N_REQ-1 frames.
- tuser and tstrb are not inspected or altered. Single-beat frames (tlast on the first beat) are legal.

Test Plan:
- Single source 0 sends a 3-beat frame (tdata 0x11, 0x22, 0x33; tlast on beat 3), ib_tready=1 -> ib_tid=0, the three beats appear in order starting 2 cycles after the first src_tvalid, then frame_cnt=1 and arb_idle=1.
- All 4 sources hold valid 2-beat frames continuously -> grant order 0,1,2,3,0; frames never interleave; ib_tid sequence matches the grant order; frame_cnt=5 after 5 frames.
- Source 1 streams 8 beats while ib_tready toggles 1,0,0,1,... -> no beat is lost or duplicated, src_tready[1] drops to 0 while count=2, ib_tdata holds stable while stalled.
- Source 2 sends single-beat frames back-to-back with tuser=8'h03 -> each beat is granted, ib_tlast=1 with ib_tuser=8'h03 passed through, exactly one idle bubble between frames.
- Assert rst for 1 cycle in the middle of a 4-beat frame from source 3 -> the next cycle shows ib_tvalid=0, src_tready=0, frame_cnt=0, arb_idle=1; the next arbitration starts from rr_ptr=0.
- With rr_ptr=3 and sources 0 and 3 both valid -> source 3 is granted first, then source 0.
